// File: rtl/idct_2d_if.sv
// Coefficient-in / pixel-out bus of the 8x8 inverse DCT.
`default_nettype none

interface idct_2d_if #(
  parameter int COEF_W = 16,
  parameter int PIX_W  = 8
);
  logic                     start;
  logic signed [COEF_W-1:0] coef_in;
  logic                     coef_valid;
  logic        [PIX_W-1:0]  pixel_out;
  logic                     valid_out;
  logic                     done;
  logic                     busy;

  modport master (
    output start, coef_in, coef_valid,
    input  pixel_out, valid_out, done, busy
  );

  modport slave (
    input  start, coef_in, coef_valid,
    output pixel_out, valid_out, done, busy
  );
endinterface

`default_nettype wire

// File: rtl/idct_2d.sv
// 8x8 2-D inverse DCT: buffer 64 coefficients, column pass, then row pass with clamped pixel output.
// Optional macro IDCT_LEVEL_SHIFT_EN adds +128 to each pixel before the clamp.
`default_nettype none

module idct_2d #(
  parameter int COEF_W = 16,
  parameter int PIX_W  = 8,
  parameter int FRAC   = 10
) (
  input wire        clk,
  input wire        rst_n,
  idct_2d_if.slave  bus
);

  localparam int ACC_W = 32;
  localparam int T_W   = 20;
  localparam int ROM_W = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PASS1 = 2'd2;
  localparam logic [1:0] S_PASS2 = 2'd3;

  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 <<< (FRAC - 1));
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);
`ifdef IDCT_LEVEL_SHIFT_EN
  localparam logic signed [ACC_W-1:0] LEVEL   = ACC_W'(128);
`else
  localparam logic signed [ACC_W-1:0] LEVEL   = ACC_W'(0);
`endif

  // C[u][x] from the phase k = (2x+1)u mod 32, folded onto one quadrant of cos(k*pi/16)
  function automatic logic signed [ROM_W-1:0] cos_rom(input logic [2:0] u, input logic [2:0] x);
    logic [7:0] prod;
    logic [4:0] k;
    logic [3:0] m;
    logic       neg;
    logic [9:0] mag;
    prod = {4'b0, x, 1'b1} * {5'b0, u};
    k    = prod[4:0];
    if (k <= 5'd8) begin
      m = k[3:0];             neg = 1'b0;
    end else if (k <= 5'd16) begin
      m = 4'(5'd16 - k);      neg = 1'b1;
    end else if (k <= 5'd24) begin
      m = 4'(k - 5'd16);      neg = 1'b1;
    end else begin
      m = 4'(6'd32 - {1'b0, k}); neg = 1'b0;
    end
    case (m)
      4'd0:    mag = 10'd512;
      4'd1:    mag = 10'd502;
      4'd2:    mag = 10'd473;
      4'd3:    mag = 10'd426;
      4'd4:    mag = 10'd362;
      4'd5:    mag = 10'd284;
      4'd6:    mag = 10'd196;
      4'd7:    mag = 10'd100;
      default: mag = 10'd0;
    endcase
    if (u == 3'd0) begin
      mag = 10'd362;
      neg = 1'b0;
    end
    return neg ? -$signed({2'b0, mag}) : $signed({2'b0, mag});
  endfunction

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [6:0]               r_cnt;
  logic [6:0]               w_cnt_nxt;
  logic                     w_f_we;
  logic                     w_t_we;
  logic                     w_valid_nxt;
  logic                     w_done_nxt;
  logic [PIX_W-1:0]         r_pixel;
  logic                     r_valid;
  logic                     r_done;

  logic signed [COEF_W-1:0] r_f [64];
  logic signed [T_W-1:0]    r_t [64];

  logic [2:0]               w_row;
  logic [2:0]               w_col;
  logic signed [T_W-1:0]    w_opd;
  logic signed [ROM_W-1:0]  w_cos;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_pix_full;
  logic [PIX_W-1:0]         w_pix;

  assign w_row = r_cnt[5:3];
  assign w_col = r_cnt[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD:  if (bus.coef_valid && r_cnt == 7'd63) w_state_nxt = S_PASS1;
      S_PASS1: if (r_cnt == 7'd63) w_state_nxt = S_PASS2;
      S_PASS2: if (r_cnt == 7'd64) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PASS2 spends one extra cycle (count 64) to emit done as it returns to IDLE
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_f_we      = 1'b0;
    w_t_we      = 1'b0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: w_cnt_nxt = 7'd0;
      S_LOAD: begin
        if (bus.coef_valid) begin
          w_f_we    = 1'b1;
          w_cnt_nxt = (r_cnt == 7'd63) ? 7'd0 : r_cnt + 7'd1;
        end
      end
      S_PASS1: begin
        w_t_we    = 1'b1;
        w_cnt_nxt = (r_cnt == 7'd63) ? 7'd0 : r_cnt + 7'd1;
      end
      S_PASS2: begin
        if (r_cnt == 7'd64) begin
          w_done_nxt = 1'b1;
          w_cnt_nxt  = 7'd0;
        end else begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + 7'd1;
        end
      end
      default: w_cnt_nxt = 7'd0;
    endcase
  end

  // Eight MAC lanes shared by both passes: column pass walks u, row pass walks v
  always_comb begin
    w_opd = '0;
    w_cos = '0;
    w_sum = '0;
    for (int j = 0; j < 8; j++) begin
      if (r_state == S_PASS1) begin
        w_opd = T_W'(r_f[{3'(j), w_col}]);
        w_cos = cos_rom(3'(j), w_row);
      end else begin
        w_opd = r_t[{w_row, 3'(j)}];
        w_cos = cos_rom(3'(j), w_col);
      end
      w_sum = w_sum + (ACC_W'(w_opd) * ACC_W'(w_cos));
    end
  end

  always_comb begin
    w_rnd      = (w_sum + HALF) >>> FRAC;
    w_pix_full = w_rnd + LEVEL;
    if (w_pix_full < 0)            w_pix = '0;
    else if (w_pix_full > PIX_MAX) w_pix = PIX_MAX[PIX_W-1:0];
    else                           w_pix = w_pix_full[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pixel <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_valid_nxt) r_pixel <= w_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (w_f_we) r_f[r_cnt[5:0]] <= bus.coef_in;
    if (w_t_we) r_t[r_cnt[5:0]] <= w_rnd[T_W-1:0];
  end

  assign bus.pixel_out = r_pixel;
  assign bus.valid_out = r_valid;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
